// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Issues one word fetch at a time and holds the returned instruction for decode
// until it is consumed. On consume, computes the next pc (sequential or branch).
// A misaligned taken branch target halts the unit until reset.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   imem_req/addr       fetch request and word address to instruction memory
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   read response (only honoured while waiting for data)
//   instr/op/instr_pc   held instruction, its opcode field and its address
//   instr_valid         held instruction is valid
//   instr_ready         decode consumes the held instruction this cycle
//   pcsrc, imm_ext      branch taken / offset, sampled only on consume
//   misalign_err        sticky: taken branch target not word aligned
//   fetch_count         number of instructions consumed (wraps)
//
// State | meaning
// RST   | first cycle after reset, no request driven
// REQ   | request driven at pc, waiting for imem_ready
// WAIT  | request accepted, waiting for imem_rvalid
// HOLD  | instruction held for decode, waiting for instr_ready
// HALT  | misaligned branch target seen, frozen until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic [31:0] imm_ext,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    RST  = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;
  logic [31:0] target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    err_d      = err_q;
    count_d    = count_q;
    imem_req   = 1'b0;
    // Branch/sequential target, modulo 2^32 by construction of the 32-bit add.
    target     = instr_pc_q + (pcsrc ? imm_ext : 32'd4);

    case (state_q)
      RST: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          // The faulting instruction still counts as consumed; pc keeps the
          // address of the last fetch so the halted state is inspectable.
          if (pcsrc && (target[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = target;
            state_d = REQ;
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = RST;
    endcase
  end

  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign op           = instr_q[6:0];
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = valid_q;
  assign misalign_err = err_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready, imem_rvalid, instr_ready, pcsrc;
  logic [31:0] imem_rdata, imm_ext;
  logic        imem_req, instr_valid, misalign_err;
  logic [31:0] imem_addr, instr, instr_pc, fetch_count;
  logic [6:0]  op;

  // Second instance with a wrapping reset pc and a free-running handshake.
  logic        imem_req_w, instr_valid_w, misalign_err_w;
  logic [31:0] imem_addr_w, instr_w, instr_pc_w, fetch_count_w;
  logic [6:0]  op_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level reference model.
  logic [31:0] m_pc, m_count, m_instr, m_ipc;
  logic        m_busy, m_held, m_err;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pcsrc(pcsrc), .imm_ext(imm_ext),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ready(1'b1), .imem_rvalid(1'b1), .imem_rdata(32'h0000_0013),
    .instr(instr_w), .op(op_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(1'b1), .pcsrc(1'b0), .imm_ext(32'h0),
    .misalign_err(misalign_err_w), .fetch_count(fetch_count_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("count", fetch_count, m_count);
    chk("err", 32'(misalign_err), 32'(m_err));
    chk("req", 32'(imem_req), 32'(!m_err && !m_busy && !m_held));
    chk("valid", 32'(instr_valid), 32'(m_held && !m_err));
    if (!m_busy && !m_held) chk("addr", imem_addr, m_pc);
    if (m_held) begin
      chk("instr", instr, m_instr);
      chk("op", 32'(op), 32'(m_instr[6:0]));
      chk("ipc", instr_pc, m_ipc);
    end
  endtask

  // One clock: check at the current negedge, drive, then advance the model.
  task automatic step(input logic r, input logic rv, input logic [31:0] rd,
                      input logic ir, input logic ps, input logic [31:0] imm);
    logic [31:0] tgt;
    check_outputs();
    imem_ready  = r;
    imem_rvalid = rv;
    imem_rdata  = rd;
    instr_ready = ir;
    pcsrc       = ps;
    imm_ext     = imm;
    @(posedge clk);
    if (!m_err) begin
      if (m_held) begin
        if (ir) begin
          m_count = m_count + 32'd1;
          m_held  = 1'b0;
          tgt = ps ? (m_ipc + imm) : (m_ipc + 32'd4);
          if (ps && (tgt % 4 != 0)) m_err = 1'b1;
          else m_pc = tgt;
        end
      end else if (m_busy) begin
        if (rv) begin
          m_busy  = 1'b0;
          m_held  = 1'b1;
          m_instr = rd;
          m_ipc   = m_pc;
        end
      end else if (r) begin
        m_busy = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] d, input logic ps, input logic [31:0] imm);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, ps, imm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_err", 32'(misalign_err), 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b1;          // late response during the RST cycle
    imem_rdata  = $urandom;
    instr_ready = 1'b1;
    #1;
    chk("rst_cycle_req", 32'(imem_req), 32'h0);
    m_pc = 32'h0; m_count = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    m_busy = 1'b0; m_held = 1'b0; m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; pcsrc = 1'b0; imm_ext = 32'h0;
    repeat (2) @(negedge clk);
    do_reset();

    // First fetch at 0; the wrapping instance runs the same three-cycle cadence.
    chk("w_addr0", imem_addr_w, 32'hFFFF_FFFC);
    chk("w_req0", 32'(imem_req_w), 32'h1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("w_req_wait", 32'(imem_req_w), 32'h0);
    step(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    chk("w_ipc", instr_pc_w, 32'hFFFF_FFFC);
    chk("op_first", 32'(op), 32'h13);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("w_addr_wrap", imem_addr_w, 32'h0000_0000);
    chk("w_req1", 32'(imem_req_w), 32'h1);
    chk("addr_seq", imem_addr, 32'h4);
    chk("count_one", fetch_count, 32'h1);

    // Memory stalls: request held, address constant, stray rvalid/pcsrc ignored.
    repeat (3) step(1'b0, 1'b1, $urandom, 1'b1, 1'b1, $urandom);
    fetch($urandom, 1'b0, 32'h0);
    chk("addr_after_stall", imem_addr, 32'h8);
    fetch($urandom, 1'b0, 32'h0);
    fetch($urandom, 1'b0, 32'h0);

    // Backward branch from 0x10; pcsrc while not consuming has no effect.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'h0);
    chk("ipc_branch", instr_pc, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    chk("addr_branch", imem_addr, 32'h8);

    // Reset while waiting for data; a late response after release is ignored.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_reset();
    step(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    chk("late_valid", 32'(instr_valid), 32'h0);
    chk("late_addr", imem_addr, 32'h0);

    // Misaligned taken branch halts with the instruction counted.
    fetch(32'h0000_0063, 1'b1, 32'h6);
    chk("halt_err", 32'(misalign_err), 32'h1);
    repeat (5) step(1'(1), 1'(1), $urandom, 1'(1), 1'(1), 32'h4);
    chk("halt_count", fetch_count, 32'h1);
    chk("halt_req", 32'(imem_req), 32'h0);
    do_reset();

    for (int i = 0; i < 4000; i++) begin
      if (m_err || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        logic [31:0] imm;
        imm = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), imm);
      end
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 imem_req  output  1  fetch request to instruction memory.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ready  input  1  memory accepts request this cycle when imem_req=1.
REQ-007 imem_rvalid  input  1  read data valid.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 instr  output  32  held instruction to decode stage.
REQ-010 op  output  7  instr[6:0], opcode field driven to main decoder.
REQ-011 instr_pc  output  32  address of held instruction.
REQ-012 instr_valid  output  1  instr/op/instr_pc valid.
REQ-013 instr_ready  input  1  decode/execute consumes held instruction this cycle.
REQ-014 pcsrc  input  1  branch taken (Zero & Branch) for held instruction.
REQ-015 imm_ext  input  32  sign-extended branch offset for held instruction.
REQ-016 misalign_err  output  1  sticky flag: branch target not word-aligned.
REQ-017 fetch_count  output  32  count of instructions consumed.

Function
REQ-018 FSM states SHALL be RST, REQ, WAIT, HOLD, HALT.
REQ-019 RST: first clock edge with rst_n=1 moves to REQ; no request driven in RST.
REQ-020 REQ: imem_req=1, imem_addr=pc; imem_ready=1 -> WAIT; else stay REQ, imem_addr stable.
REQ-021 WAIT: imem_req=0; on imem_rvalid=1 capture imem_rdata into instr, pc into instr_pc, set instr_valid=1, -> HOLD.
REQ-022 imem_rvalid SHALL be ignored in every state except WAIT.
REQ-023 HOLD: instr, op, instr_pc stable and instr_valid=1 until instr_ready=1.
REQ-024 HOLD with instr_ready=1: pcsrc, imm_ext sampled that cycle only; next pc = pcsrc ? instr_pc+imm_ext : instr_pc+4; instr_valid=0 next cycle; fetch_count+1; -> REQ.
REQ-025 pcsrc/imm_ext values outside the HOLD&instr_ready cycle SHALL have no effect.
REQ-026 Address arithmetic SHALL be 32-bit modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000; negative imm_ext wraps).
REQ-027 Taken target with bits[1:0]!=0: misalign_err=1 (sticky), instruction still counted, -> HALT; pc not updated.
REQ-028 HALT: imem_req=0, instr_valid=0, outputs frozen; exit only by reset.
REQ-029 fetch_count wraps 0xFFFF_FFFF -> 0.
REQ-030 Minimum throughput: one instruction per 3 cycles (REQ accept, WAIT rvalid next cycle, HOLD consumed immediately).
REQ-031 At most one request outstanding; no new request before previous response consumed.
REQ-032 op SHALL equal instr[6:0] combinationally at all times.

Reset
REQ-033 rst_n=0 SHALL immediately: state=RST, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0, misalign_err=0, fetch_count=0.
REQ-034 Reset mid-request (REQ/WAIT/HOLD) SHALL abandon the transaction; a late imem_rvalid after reset release SHALL be ignored (arrives outside WAIT).

Verification
REQ-035 Reset release, imem_ready=1, rvalid next cycle with 32'h00500093, instr_ready=1 -> imem_addr=0x0, instr_valid 1 cycle, op=7'h13, next imem_addr=0x4, fetch_count=1.
REQ-036 imem_ready low 3 cycles in REQ -> imem_req held high, imem_addr constant 0x4 throughout, single transaction.
REQ-037 Held instr_pc=0x10, pcsrc=1, imm_ext=0xFFFF_FFF8 on consume -> next imem_addr=0x08; pcsrc=1 while instr_ready=0 -> no effect.
REQ-038 RESET_PC=0xFFFF_FFFC, not taken -> second fetch imem_addr=0x0000_0000.
REQ-039 pcsrc=1, imm_ext=0x6 at instr_pc=0x0 -> misalign_err=1, imem_req stays 0, fetch_count=1 until rst_n pulse clears all.
REQ-040 rst_n pulsed low in WAIT, rvalid arrives in REQ after release -> ignored, instr_valid stays 0, fetch restarts at RESET_PC.
